mc_datapath: RTL and testbench

MC_DATAPATH -- requirements
Module: mc_datapath

---
 rtl/mc_datapath_if.sv | 30 +++
 rtl/mc_datapath.sv | 202 ++++++++++++++++++++
 tb/tb_mc_datapath.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_datapath_if.sv
// Shared memory port of the multicycle datapath.
// The datapath is master; the memory model or fabric is slave.
interface mc_datapath_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset datapath sharing one memory port
// between instruction fetch and load/store.
module mc_datapath #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    mc_datapath_if.master     mem,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic [31:0]       retired
);
    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       mdr_q, mdr_d;
    logic [31:0]       ret_q, ret_d;
    logic [31:0]       rf_q [32];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, pc32, br_tgt, j_tgt;
    logic [31:0] alu_res;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign funct = ir_q[5:0];
    assign simm  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign pc32  = 32'(pc_q);

    // pc_q is already PC+4 once the instruction is in DECODE
    assign br_tgt = pc32 + {simm[29:0], 2'b00};
    assign j_tgt  = {pc32[31:28], ir_q[25:0], 2'b00};

    logic is_r, f_add, f_sub, f_and, f_or, f_slt, r_ok;
    logic is_addi, is_lw, is_sw, is_beq, is_j, is_jal;

    assign is_r    = op == 6'h00;
    assign f_add   = is_r && funct == 6'h20;
    assign f_sub   = is_r && funct == 6'h22;
    assign f_and   = is_r && funct == 6'h24;
    assign f_or    = is_r && funct == 6'h25;
    assign f_slt   = is_r && funct == 6'h2A;
    assign r_ok    = f_add | f_sub | f_and | f_or | f_slt;
    assign is_addi = op == 6'h08;
    assign is_lw   = op == 6'h23;
    assign is_sw   = op == 6'h2B;
    assign is_beq  = op == 6'h04;
    assign is_j    = op == 6'h02;
    assign is_jal  = op == 6'h03;

    always_comb begin
        alu_res = a_q + simm;
        unique case (1'b1)
            f_add:   alu_res = a_q + b_q;
            f_sub:   alu_res = a_q - b_q;
            f_and:   alu_res = a_q & b_q;
            f_or:    alu_res = a_q | b_q;
            f_slt:   alu_res = {31'b0, $signed(a_q) < $signed(b_q)};
            default: alu_res = a_q + simm;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        ret_d    = ret_q;
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = alu_q;
        unique case (state_q)
            FETCH: begin
                if (mem.mem_ack) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d   = rf_q[rs];
                b_d   = rf_q[rt];
                alu_d = br_tgt;
                unique case (1'b1)
                    is_j: begin
                        pc_d    = j_tgt[ADDR_W-1:0];
                        ret_d   = ret_q + 32'd1;
                        state_d = FETCH;
                    end
                    is_jal: begin
                        pc_d     = j_tgt[ADDR_W-1:0];
                        rf_we    = 1'b1;
                        rf_waddr = 5'(LINK_REG);
                        rf_wdata = pc32;
                        ret_d    = ret_q + 32'd1;
                        state_d  = FETCH;
                    end
                    (r_ok | is_addi | is_lw | is_sw | is_beq):
                        state_d = EXEC;
                    default: state_d = HALT;
                endcase
            end
            EXEC: begin
                unique case (1'b1)
                    is_beq: begin
                        if (a_q == b_q) pc_d = alu_q[ADDR_W-1:0];
                        ret_d   = ret_q + 32'd1;
                        state_d = FETCH;
                    end
                    (is_lw | is_sw): begin
                        alu_d   = alu_res;
                        state_d = MEM;
                    end
                    default: begin
                        alu_d   = alu_res;
                        state_d = WB;
                    end
                endcase
            end
            MEM: begin
                if (mem.mem_ack) begin
                    if (is_sw) begin
                        ret_d   = ret_q + 32'd1;
                        state_d = FETCH;
                    end else begin
                        mdr_d   = mem.mem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we    = 1'b1;
                rf_waddr = is_r ? rd : rt;
                rf_wdata = is_lw ? mdr_q : alu_q;
                ret_d    = ret_q + 32'd1;
                state_d  = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            ret_q   <= ret_d;
        end
    end

    // register 0 is never written, so it always reads zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // request is gated by reset so an in-flight transfer drops at once
    assign mem.mem_req   = rst && (state_q == FETCH || state_q == MEM);
    assign mem.mem_we    = state_q == MEM && is_sw;
    assign mem.mem_addr  = state_q == MEM ? alu_q[ADDR_W-1:0] : pc_q;
    assign mem.mem_wdata = (state_q == MEM && is_sw) ? b_q : '0;

    assign pc_out  = pc_q;
    assign halted  = state_q == HALT;
    assign retired = ret_q;
endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: directed programs, memory model
// with programmable ack delay, transfer monitor checking expected bus traffic.
module tb_mc_datapath;
    localparam int unsigned AW = 32;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc_out;
    logic          halted;
    logic [31:0]   retired;

    mc_datapath_if #(.ADDR_W(AW)) bus ();

    mc_datapath #(.ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .mem     (bus),
        .pc_out  (pc_out),
        .halted  (halted),
        .retired (retired)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    xfer_t       exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          ack_dly = 0;
    bit          force_ack = 1'b0;
    int          cyc = 0;
    logic [31:0] pa;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // memory responder: decides ack just after the falling edge
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            bus.mem_ack = 1'b0;
            if (force_ack) begin
                bus.mem_ack = 1'b1;
                cnt = 0;
            end else if (bus.mem_req) begin
                if (cnt >= ack_dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr[11:2]];
                    if (bus.mem_we)
                        mem[bus.mem_addr[11:2]] = bus.mem_wdata;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // monitor: samples one unit before the rising edge
    initial begin
        logic        p_req, p_ack, p_we;
        logic [31:0] p_addr, p_wd;
        xfer_t       e;
        p_req = 0; p_ack = 0; p_we = 0; p_addr = 0; p_wd = 0;
        forever begin
            @(negedge clk);
            #4;
            if (rst && bus.mem_req) begin
                if (p_req && !p_ack) begin
                    chk("hold_we", {31'b0, bus.mem_we}, {31'b0, p_we});
                    chk("hold_addr", bus.mem_addr, p_addr);
                    chk("hold_wdata", bus.mem_wdata, p_wd);
                end
                if (bus.mem_ack) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_extra: got transfer %h want none",
                                 bus.mem_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_we", {31'b0, bus.mem_we}, {31'b0, e.we});
                        chk("sb_addr", bus.mem_addr, e.addr);
                        if (e.we) chk("sb_wdata", bus.mem_wdata, e.wdata);
                    end
                end
            end
            p_req  = rst && bus.mem_req;
            p_ack  = bus.mem_ack;
            p_we   = bus.mem_we;
            p_addr = bus.mem_addr;
            p_wd   = bus.mem_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_r(input logic [5:0] f,
        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'h00, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] o,
        input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
        return {o, s, t, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] o,
        input logic [25:0] tg);
        return {o, tg};
    endfunction

    task automatic push_x(input logic we, input logic [31:0] a,
                          input logic [31:0] d);
        xfer_t x;
        x.we = we; x.addr = a; x.wdata = d;
        exp_q.push_back(x);
    endtask

    // place an instruction at pa and expect its fetch
    task automatic emit(input logic [31:0] w);
        mem[pa[11:2]] = w;
        push_x(1'b0, pa, 32'h0);
        pa = pa + 32'd4;
    endtask

    task automatic chk_reset();
        chk("rst_req", {31'b0, bus.mem_req}, 32'h0);
        chk("rst_we", {31'b0, bus.mem_we}, 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_retired", retired, 32'h0);
    endtask

    task automatic begin_reset(input int dly);
        rst = 1'b0;
        ack_dly = dly;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        pa = 32'h0;
        #2;
        chk_reset();
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_halt(input int maxc);
        int k;
        k = 0;
        while (!halted && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("halt_seen", {31'b0, halted}, 32'h1);
    endtask

    task automatic wait_ret(input logic [31:0] n, input int maxc,
                            output int at);
        int k;
        k = 0;
        while (retired != n && k < maxc) begin
            @(negedge clk);
            k++;
        end
        at = cyc;
        chk("ret_reach", retired, n);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("sb_drain", exp_q.size(), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        int c1, c2;
        #1;

        // arithmetic, logic, stores, beq not taken, r0, halt
        begin_reset(0);
        emit(enc_i(6'h08, 0, 1, 16'd5));
        emit(enc_i(6'h08, 0, 2, 16'hFFFD));
        emit(enc_r(6'h20, 1, 2, 3));
        emit(enc_r(6'h22, 1, 2, 5));
        emit(enc_r(6'h24, 1, 2, 6));
        emit(enc_r(6'h25, 1, 2, 7));
        emit(enc_r(6'h2A, 2, 1, 8));
        emit(enc_r(6'h2A, 1, 2, 9));
        emit(enc_i(6'h2B, 0, 5, 16'h80));
        push_x(1'b1, 32'h80, 32'd8);
        emit(enc_i(6'h2B, 0, 6, 16'h84));
        push_x(1'b1, 32'h84, 32'd5);
        emit(enc_i(6'h2B, 0, 7, 16'h88));
        push_x(1'b1, 32'h88, 32'hFFFFFFFD);
        emit(enc_i(6'h2B, 0, 8, 16'h8C));
        push_x(1'b1, 32'h8C, 32'd1);
        emit(enc_i(6'h2B, 0, 9, 16'h90));
        push_x(1'b1, 32'h90, 32'd0);
        emit(enc_i(6'h04, 0, 1, 16'd5));
        emit(enc_r(6'h20, 1, 1, 0));
        emit(enc_i(6'h2B, 0, 0, 16'h94));
        push_x(1'b1, 32'h94, 32'd0);
        emit(enc_i(6'h2B, 0, 3, 16'h98));
        push_x(1'b1, 32'h98, 32'd2);
        emit(32'hFC000000);
        release_rst();
        repeat (12) @(negedge clk);
        chk("t1_retired12", retired, 32'd3);
        chk("t1_r3", dut.rf_q[3], 32'd2);
        wait_halt(300);
        chk("t1_halt_pc", pc_out, 32'h48);
        chk("t1_halt_req", {31'b0, bus.mem_req}, 32'h0);
        repeat (3) @(negedge clk);
        chk("t1_halt_ret", retired, 32'd17);
        drain();

        // store then load with three wait cycles per transfer
        begin_reset(3);
        emit(enc_i(6'h08, 0, 1, 16'd5));
        emit(enc_i(6'h2B, 0, 1, 16'h40));
        push_x(1'b1, 32'h40, 32'd5);
        emit(enc_i(6'h23, 0, 4, 16'h40));
        push_x(1'b0, 32'h40, 32'h0);
        emit(enc_i(6'h2B, 0, 4, 16'h44));
        push_x(1'b1, 32'h44, 32'd5);
        emit(32'hFC000000);
        release_rst();
        wait_ret(32'd1, 50, c1);
        wait_ret(32'd3, 80, c2);
        chk("t2_cycles", c2 - c1, 32'd21);
        wait_halt(100);
        chk("t2_r4", dut.rf_q[4], 32'd5);
        drain();

        // beq looping on itself every three cycles
        begin_reset(0);
        emit(enc_i(6'h08, 0, 1, 16'd5));
        emit(enc_i(6'h04, 1, 1, 16'hFFFF));
        push_x(1'b0, 32'h4, 32'h0);
        push_x(1'b0, 32'h4, 32'h0);
        release_rst();
        repeat (4) @(negedge clk);
        chk("t3_pc0", pc_out, 32'h4);
        chk("t3_ret0", retired, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            repeat (3) @(negedge clk);
            chk("t3_pc", pc_out, 32'h4);
            chk("t3_ret", retired, 32'(1 + k));
        end
        drain();

        // jal at 0x10 then j, each two cycles
        begin_reset(0);
        for (int k = 0; k < 4; k++) emit(enc_r(6'h20, 0, 0, 0));
        emit(enc_j(6'h03, 26'h100));
        pa = 32'h400;
        emit(enc_i(6'h2B, 0, 31, 16'h60));
        push_x(1'b1, 32'h60, 32'h14);
        emit(enc_j(6'h02, 26'h80));
        pa = 32'h200;
        emit(32'hFC000000);
        release_rst();
        wait_ret(32'd4, 40, c1);
        wait_ret(32'd5, 10, c2);
        chk("t4_jal_cyc", c2 - c1, 32'd2);
        wait_ret(32'd6, 20, c1);
        wait_ret(32'd7, 10, c2);
        chk("t4_j_cyc", c2 - c1, 32'd2);
        wait_halt(40);
        chk("t4_r31", dut.rf_q[31], 32'h14);
        chk("t4_pc", pc_out, 32'h204);
        chk("t4_ret", retired, 32'd7);
        drain();

        // reset during a load wait, late ack ignored
        begin_reset(3);
        emit(enc_i(6'h08, 0, 1, 16'd5));
        emit(enc_i(6'h23, 0, 4, 16'h40));
        mem[16] = 32'h00001234;
        release_rst();
        c1 = 0;
        while (!(bus.mem_req && bus.mem_addr == 32'h40) && c1 < 60) begin
            @(negedge clk);
            c1++;
        end
        chk("t5_in_mem", bus.mem_addr, 32'h40);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("t5_req_rst", {31'b0, bus.mem_req}, 32'h0);
        drain();
        @(negedge clk);
        force_ack = 1'b1;
        #2;
        chk("t5_req_ack", {31'b0, bus.mem_req}, 32'h0);
        chk("t5_r4", dut.rf_q[4], 32'h0);
        chk("t5_addr", bus.mem_addr, 32'h0);
        @(negedge clk);
        force_ack = 1'b0;
        pa = 32'h0;
        emit(enc_i(6'h08, 0, 1, 16'd5));
        emit(enc_i(6'h23, 0, 4, 16'h40));
        push_x(1'b0, 32'h40, 32'h0);
        emit(32'hFC000000);
        release_rst();
        #2;
        chk("t5_req_rise", {31'b0, bus.mem_req}, 32'h1);
        wait_halt(100);
        chk("t5_r4_load", dut.rf_q[4], 32'h1234);
        chk("t5_ret", retired, 32'd2);
        drain();

        // unknown funct under opcode 0 halts without retiring
        begin_reset(0);
        emit(enc_r(6'h21, 1, 2, 3));
        release_rst();
        wait_halt(20);
        chk("t6_pc", pc_out, 32'h4);
        chk("t6_ret", retired, 32'h0);
        drain();
        begin_reset(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
